// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight and
// buffers returned instructions with their PCs in a small FIFO for decode.
module fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

    state_e        state;
    logic [63:0]   fetch_pc;
    logic [63:0]   req_pc;
    logic          started;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [31:0]   instr_mem [DEPTH];
    logic [63:0]   pc_mem    [DEPTH];

    logic req_fire;
    logic push;
    logic pop;
    logic unused_pc_bits;

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // valid never depends on ready. The response channel has no backpressure.
    assign imem_req_valid = started && (state == IDLE) && (count < FULL) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop            = out_valid && out_ready && !redirect_valid;

    assign out_valid = (count != '0);
    assign out_instr = instr_mem[head];
    assign out_pc    = pc_mem[head];

    // Redirect targets are word aligned; the low two bits carry no information.
    assign unused_pc_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            started  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                // Flush everything; an outstanding request's response must be swallowed.
                fetch_pc <= {redirect_pc[63:2], 2'b00};
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                if (state != IDLE) begin
                    state <= imem_rsp_valid ? IDLE : DROP;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (req_fire) begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 64'd4;
                            state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            instr_mem[tail] <= imem_rsp_data;
                            pc_mem[tail]    <= req_pc;
                            tail            <= tail + AW'(1);
                            state           <= IDLE;
                        end
                    end
                    DROP: begin
                        if (imem_rsp_valid) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (pop) begin
                    head <= head + AW'(1);
                end

                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a memory model driven per cycle plus a PC-stream scoreboard.
module tb_fetch_queue;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // stimulus controls
    bit          ready_rand, out_ready_rand, rand_redir, instr_const, force_redir;
    logic        out_ready_fix;
    logic [63:0] force_pc;
    int          lat_min, lat_max;

    // memory model: one outstanding request answered after a latency
    bit          pending;
    int          pend_cnt;
    logic [63:0] pend_addr;

    // reference model: the program-order PC stream seen by memory and by decode
    logic [63:0] exp_req_pc, exp_out_pc;
    logic [63:0] exp_q[$];
    logic [63:0] req_log[$];
    logic [63:0] pop_pc_log[$];
    logic [31:0] pop_instr_log[$];
    int          req_cyc[$];
    int          pop_cyc[$];

    // per-cycle samples
    logic        s_req_valid, s_fire, s_pop, s_rsp, s_redir, s_out_valid, redir_prev;
    logic [63:0] s_addr, s_out_pc;
    logic [31:0] s_out_instr;

    int cyc, last_rsp_cyc, n_checks, n_fail, n_pops;

    function automatic logic [31:0] mem_func(input logic [63:0] pc);
        if (instr_const) return 32'h0000_0013;
        return pc[31:0] ^ pc[63:32] ^ 32'h5a5a_0013;
    endfunction

    // driver + scoreboard for one clock cycle; entered and left at posedge+1
    task automatic cycle();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pending) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_func(pend_addr);
                pending        = 1'b0;
                last_rsp_cyc   = cyc;
            end
        end
        imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else if (rand_redir && $urandom_range(0, 15) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = {$urandom, $urandom};
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = {$urandom, $urandom};
        end
        out_ready = out_ready_rand ? 1'($urandom_range(0, 1)) : out_ready_fix;
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        s_rsp       = imem_rsp_valid;
        s_redir     = redirect_valid;
        s_fire      = imem_req_valid && imem_req_ready;
        s_pop       = out_valid && out_ready && !redirect_valid;

        if (rst_n) begin
            if (redir_prev) begin
                n_checks++;
                if (s_out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_redirect_empty: out_valid=%b expected 0 (cycle %0d)", s_out_valid, cyc);
                end
            end
            if (s_redir) begin
                n_checks++;
                if (s_req_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_during_redirect: imem_req_valid=%b expected 0 (cycle %0d)", s_req_valid, cyc);
                end
            end
            if (s_pop) begin
                n_checks++;
                if (s_out_pc !== exp_out_pc) begin
                    n_fail++;
                    $display("FAIL out_pc: got %h expected %h (cycle %0d)", s_out_pc, exp_out_pc, cyc);
                end
                n_checks++;
                if (s_out_instr !== mem_func(exp_out_pc)) begin
                    n_fail++;
                    $display("FAIL out_instr: got %h expected %h (cycle %0d)", s_out_instr, mem_func(exp_out_pc), cyc);
                end
                pop_pc_log.push_back(s_out_pc);
                pop_instr_log.push_back(s_out_instr);
                pop_cyc.push_back(cyc);
                exp_out_pc = exp_out_pc + 64'd4;
                n_pops++;
            end
            if (s_fire) begin
                n_checks++;
                if (s_addr !== exp_req_pc) begin
                    n_fail++;
                    $display("FAIL req_addr: got %h expected %h (cycle %0d)", s_addr, exp_req_pc, cyc);
                end
                n_checks++;
                if (pending) begin
                    n_fail++;
                    $display("FAIL req_while_busy: got outstanding=1 expected 0 (cycle %0d)", cyc);
                end
                req_log.push_back(s_addr);
                req_cyc.push_back(cyc);
                exp_req_pc = exp_req_pc + 64'd4;
                pending    = 1'b1;
                pend_addr  = s_addr;
                pend_cnt   = $urandom_range(lat_min, lat_max);
            end
            if (s_redir) begin
                exp_req_pc = {redirect_pc[63:2], 2'b00};
                exp_out_pc = {redirect_pc[63:2], 2'b00};
            end
            redir_prev = s_redir;
        end else begin
            exp_req_pc = RESET_PC;
            exp_out_pc = RESET_PC;
            redir_prev = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        pop_pc_log.delete();
        pop_instr_log.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        force_redir = 1'b0;
        rand_redir  = 1'b0;
        ready_rand  = 1'b0;
        pending     = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        n_checks++;
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", s_req_valid); end
        n_checks++;
        if (s_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h expected %h", s_addr, RESET_PC); end
        n_checks++;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", s_out_valid); end
        n_checks++;
        if (s_out_pc !== 64'd0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", s_out_pc); end
        n_checks++;
        if (s_out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out_instr: got %h expected 0", s_out_instr); end
        rst_n = 1'b1;
        cycle();
        n_checks++;
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL release_req_valid: got %b expected 0", s_req_valid); end
        cycle();
        n_checks++;
        if (s_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b expected 1", s_req_valid); end
    endtask

    task automatic test_fetch_seq();
        instr_const   = 1'b1;
        lat_min       = 1;
        lat_max       = 1;
        out_ready_fix = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) cycle();
        exp_q = {64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
        n_checks++;
        if (req_log.size() < 3 || pop_pc_log.size() < 3) begin
            n_fail++;
            $display("FAIL fetch_seq_count: got %0d req %0d pops expected at least 3 each", req_log.size(), pop_pc_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (req_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL seq_req_addr[%0d]: got %h expected %h", i, req_log[i], exp_q[i]); end
                n_checks++;
                if (pop_pc_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL seq_out_pc[%0d]: got %h expected %h", i, pop_pc_log[i], exp_q[i]); end
                n_checks++;
                if (pop_instr_log[i] !== 32'h13) begin n_fail++; $display("FAIL seq_out_instr[%0d]: got %h expected 00000013", i, pop_instr_log[i]); end
            end
            n_checks++;
            if (req_cyc[1] - req_cyc[0] != 2) begin n_fail++; $display("FAIL req_spacing: got %0d expected 2", req_cyc[1] - req_cyc[0]); end
            n_checks++;
            if (pop_cyc[0] - req_cyc[0] != 2) begin n_fail++; $display("FAIL first_latency: got %0d expected 2", pop_cyc[0] - req_cyc[0]); end
        end
        instr_const = 1'b0;
    endtask

    task automatic test_backpressure();
        lat_min       = 1;
        lat_max       = 1;
        out_ready_fix = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) cycle();
        n_checks++;
        if (req_log.size() != 2) begin n_fail++; $display("FAIL full_req_count: got %0d expected 2", req_log.size()); end
        n_checks++;
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_req_valid: got %b expected 0", s_req_valid); end
        out_ready_fix = 1'b1;
        cycle();
        n_checks++;
        if (s_pop !== 1'b1 || s_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL pop_cycle: got pop=%b req_valid=%b expected pop=1 req_valid=0", s_pop, s_req_valid);
        end
        out_ready_fix = 1'b0;
        cycle();
        n_checks++;
        if (s_req_valid !== 1'b1) begin n_fail++; $display("FAIL after_pop_req_valid: got %b expected 1", s_req_valid); end
        out_ready_fix = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
    endtask

    task automatic test_redirect_wait();
        int acc, fire_cyc;
        bit found, fired, saw;
        logic [63:0] fire_addr;
        lat_min       = 4;
        lat_max       = 4;
        out_ready_fix = 1'b1;
        do_reset();
        found = 0; fired = 0; saw = 0; acc = 0; fire_cyc = 0; fire_addr = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_fire) begin found = 1; acc = cyc - 1; break; end
        end
        force_redir = 1'b1;
        force_pc    = 64'h8000_1002;
        cycle();
        for (int i = 0; i < 12; i++) begin
            cycle();
            saw = saw | s_out_valid;
            if (s_fire) begin fired = 1; fire_cyc = cyc - 1; fire_addr = s_addr; break; end
        end
        n_checks++;
        if (!(found && fired)) begin
            n_fail++; $display("FAIL redirect_wait_timeout: got found=%b fired=%b expected 1 1", found, fired);
        end else begin
            n_checks++;
            if (last_rsp_cyc != acc + 4) begin n_fail++; $display("FAIL dropped_rsp_cycle: got %0d expected %0d", last_rsp_cyc, acc + 4); end
            n_checks++;
            if (fire_cyc != last_rsp_cyc + 1) begin n_fail++; $display("FAIL refetch_cycle: got %0d expected %0d", fire_cyc, last_rsp_cyc + 1); end
            n_checks++;
            if (fire_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL refetch_addr: got %h expected 80001000", fire_addr); end
            n_checks++;
            if (saw !== 1'b0) begin n_fail++; $display("FAIL dropped_rsp_visible: got out_valid=%b expected 0", saw); end
        end
    endtask

    task automatic test_redirect_rsp_pop();
        bit found;
        lat_min       = 1;
        lat_max       = 1;
        out_ready_fix = 1'b0;
        do_reset();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_out_valid && s_fire) begin found = 1; break; end
        end
        force_redir   = 1'b1;
        force_pc      = 64'h0000_0000_0000_1236;
        out_ready_fix = 1'b1;
        cycle();
        n_checks++;
        if (!(found && s_rsp && s_out_valid)) begin
            n_fail++; $display("FAIL collision_setup: got found=%b rsp=%b out_valid=%b expected 1 1 1", found, s_rsp, s_out_valid);
        end
        cycle();
        n_checks++;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL collision_flush: got out_valid=%b expected 0", s_out_valid); end
        n_checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 64'h1234) begin
            n_fail++; $display("FAIL collision_refetch: got valid=%b addr=%h expected 1 %h", s_req_valid, s_addr, 64'h1234);
        end
        for (int i = 0; i < 8; i++) cycle();
    endtask

    task automatic test_back_to_back_wrap();
        bit found;
        lat_min = 1;
        lat_max = 1;
        out_ready_fix = 1'b0;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            found = 0;
            out_ready_fix = 1'b0;
            for (int i = 0; i < 20; i++) begin
                cycle();
                if (s_out_valid && s_fire) begin found = 1; break; end
            end
            out_ready_fix = 1'b1;
            cycle();
            n_checks++;
            if (!(found && s_pop && s_rsp)) begin
                n_fail++; $display("FAIL wrap_push_pop[%0d]: got found=%b pop=%b rsp=%b expected 1 1 1", it, found, s_pop, s_rsp);
            end
            cycle();
            n_checks++;
            if (s_out_valid !== 1'b1 || s_pop !== 1'b1) begin
                n_fail++; $display("FAIL wrap_count_kept[%0d]: got out_valid=%b pop=%b expected 1 1", it, s_out_valid, s_pop);
            end
        end
        n_checks++;
        if (n_pops < 8) begin n_fail++; $display("FAIL wrap_pops: got %0d expected >= 8", n_pops); end
    endtask

    task automatic test_reset_mid();
        bit found, fired, saw;
        logic [63:0] fire_addr;
        lat_min       = 3;
        lat_max       = 3;
        out_ready_fix = 1'b0;
        do_reset();
        found = 0; fired = 0; saw = 0; fire_addr = '0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_out_valid && s_fire) begin found = 1; break; end
        end
        rst_n = 1'b0;
        cycle();
        n_checks++;
        if (!found || s_req_valid !== 1'b0 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_valids: got found=%b req_valid=%b out_valid=%b expected 1 0 0", found, s_req_valid, s_out_valid);
        end
        n_checks++;
        if (s_out_pc !== 64'd0 || s_out_instr !== 32'd0 || s_addr !== RESET_PC) begin
            n_fail++; $display("FAIL async_reset_data: got pc=%h instr=%h addr=%h expected 0 0 %h", s_out_pc, s_out_instr, s_addr, RESET_PC);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
        n_checks++;
        if (s_rsp !== 1'b1) begin n_fail++; $display("FAIL late_rsp_setup: got rsp=%b expected 1", s_rsp); end
        for (int i = 0; i < 6; i++) begin
            cycle();
            saw = saw | s_out_valid;
            if (s_fire) begin fired = 1; fire_addr = s_addr; break; end
        end
        n_checks++;
        if (!fired || fire_addr !== RESET_PC) begin
            n_fail++; $display("FAIL post_reset_req: got fired=%b addr=%h expected 1 %h", fired, fire_addr, RESET_PC);
        end
        n_checks++;
        if (saw !== 1'b0) begin n_fail++; $display("FAIL late_rsp_pushed: got out_valid=%b expected 0", saw); end
    endtask

    task automatic test_random();
        int pops_before;
        lat_min        = 1;
        lat_max        = 4;
        do_reset();
        ready_rand     = 1'b1;
        out_ready_rand = 1'b1;
        rand_redir     = 1'b1;
        pops_before    = n_pops;
        for (int i = 0; i < 3000; i++) cycle();
        rand_redir     = 1'b0;
        ready_rand     = 1'b0;
        out_ready_rand = 1'b0;
        out_ready_fix  = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        n_checks++;
        if (n_pops - pops_before < 150) begin
            n_fail++; $display("FAIL random_progress: got %0d pops expected >= 150", n_pops - pops_before);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        ready_rand = 0; out_ready_rand = 0; rand_redir = 0; instr_const = 0; force_redir = 0;
        out_ready_fix = 1'b0; force_pc = '0; lat_min = 1; lat_max = 1;
        pending = 0; pend_cnt = 0; pend_addr = '0;
        exp_req_pc = RESET_PC; exp_out_pc = RESET_PC; redir_prev = 1'b0;
        cyc = 0; last_rsp_cyc = 0; n_checks = 0; n_fail = 0; n_pops = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_fetch_seq();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp_pop();
        test_back_to_back_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
